// File: rtl/fitness_evaluator_pkg.sv
// Shared definitions for the fitness evaluator: FSM state encoding and the
// arithmetic helpers used by the scoring datapath.
package fitness_evaluator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Operands are zero-extended to 64 bits; width selects the saturation limit (1..64).
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] val,
                                           input int unsigned width);
      logic [64:0] sum;
      logic [63:0] limit;
      sum   = {1'b0, acc} + {1'b0, val};
      limit = {64{1'b1}} >> (64 - width);
      if (sum > {1'b0, limit}) begin
         return limit;
      end
      return sum[63:0];
   endfunction

   function automatic logic [63:0] abs_diff(input logic [63:0] p,
                                            input logic [63:0] q);
      return (p >= q) ? (p - q) : (q - p);
   endfunction

endpackage

// File: rtl/fitness_target_table.sv
// Target sample RAM: one write port, one synchronous read port with registered
// data. A same-address write returns the previous contents on the read port.
module fitness_target_table #(
   parameter int AddrWidth = 4,
   parameter int DataWidth = 21
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [DataWidth-1:0] wdata,
   input  logic [AddrWidth-1:0] raddr,
   output logic [DataWidth-1:0] rdata
);

   logic [DataWidth-1:0] mem [0:(1<<AddrWidth)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/fitness_evaluator.sv
// Scores a line y = a*x + b against the target table: saturating sum of
// |y(x) - target[x]| over all sample points, returned with a one-cycle finish.
module fitness_evaluator
   import fitness_evaluator_pkg::*;
#(
   parameter int IndividualWidth    = 32,
   parameter int ErrorWidth         = 32,
   parameter int SampleAddressWidth = 4,
   parameter int TargetWidth        = IndividualWidth / 2 + SampleAddressWidth + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [IndividualWidth-1:0]    individual,
   output logic                          finish,
   output logic [ErrorWidth-1:0]         error,
   output logic                          busy,
   input  logic                          tableWe,
   input  logic [SampleAddressWidth-1:0] tableAddr,
   input  logic [TargetWidth-1:0]        tableData
);

   localparam int HalfWidth = IndividualWidth / 2;
   localparam int ProdWidth = HalfWidth + SampleAddressWidth;
   localparam int SumWidth  = ProdWidth + 1;

   state_t                        state_reg, state_next;
   logic [HalfWidth-1:0]          a_reg, a_next;
   logic [HalfWidth-1:0]          b_reg, b_next;
   logic [SampleAddressWidth:0]   x_reg, x_next;
   logic                          rd_valid_reg, rd_valid_next;
   logic [SampleAddressWidth-1:0] rd_idx_reg, rd_idx_next;
   logic [ErrorWidth-1:0]         acc_reg, acc_next;
   logic [ErrorWidth-1:0]         error_reg, error_next;

   logic [TargetWidth-1:0]        rd_data;
   logic [ProdWidth-1:0]          product;
   logic [SumWidth-1:0]           y;
   logic [63:0]                   diff;

   // Writes are gated by busy so the table cannot change under an evaluation.
   fitness_target_table #(
      .AddrWidth(SampleAddressWidth),
      .DataWidth(TargetWidth)
   ) u_table (
      .clk  (clk),
      .we   (tableWe && !busy),
      .waddr(tableAddr),
      .wdata(tableData),
      .raddr(x_reg[SampleAddressWidth-1:0]),
      .rdata(rd_data)
   );

   // rd_idx_reg tracks which sample the registered read data belongs to.
   assign product = ProdWidth'(a_reg) * ProdWidth'(rd_idx_reg);
   assign y       = SumWidth'(product) + SumWidth'(b_reg);
   assign diff    = abs_diff(64'(y), 64'(rd_data));

   always_comb begin
      state_next    = state_reg;
      a_next        = a_reg;
      b_next        = b_reg;
      x_next        = x_reg;
      rd_valid_next = 1'b0;
      rd_idx_next   = rd_idx_reg;
      acc_next      = acc_reg;
      error_next    = error_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               a_next     = individual[IndividualWidth-1:HalfWidth];
               b_next     = individual[HalfWidth-1:0];
               acc_next   = '0;
               x_next     = '0;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // x_reg's top bit marks that every address has been issued.
            if (!x_reg[SampleAddressWidth]) begin
               rd_valid_next = 1'b1;
               rd_idx_next   = x_reg[SampleAddressWidth-1:0];
               x_next        = x_reg + 1'b1;
            end
            if (rd_valid_reg) begin
               acc_next = ErrorWidth'(sat_add(64'(acc_reg), diff, ErrorWidth));
               if (&rd_idx_reg) begin
                  error_next = acc_next;
                  state_next = ST_FINISH;
               end
            end
         end
         ST_FINISH: state_next = ST_HOLD;
         ST_HOLD:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         x_reg        <= '0;
         rd_valid_reg <= 1'b0;
         rd_idx_reg   <= '0;
         acc_reg      <= '0;
         error_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         a_reg        <= a_next;
         b_reg        <= b_next;
         x_reg        <= x_next;
         rd_valid_reg <= rd_valid_next;
         rd_idx_reg   <= rd_idx_next;
         acc_reg      <= acc_next;
         error_reg    <= error_next;
      end
   end

   assign finish = (state_reg == ST_FINISH);
   assign busy   = (state_reg != ST_IDLE);
   assign error  = error_reg;

endmodule

// File: tb/tb_fitness_evaluator.sv
// Self-checking bench for fitness_evaluator: a default-width instance and an
// 8-bit-error instance share all stimulus; results come from a sum-of-errors model.
module tb_fitness_evaluator;

   localparam int N   = 16;
   localparam int TW  = 21;
   localparam int BIG = 1000;

   logic        clk = 1'b0;
   logic        rst, start, tableWe;
   logic [31:0] individual;
   logic [3:0]  tableAddr;
   logic [20:0] tableData;
   logic        finish, busy, finish8, busy8;
   logic [31:0] error;
   logic [7:0]  error8;

   int errors = 0;
   int checks = 0;
   longint tgt [N];

   typedef struct {
      int     a;
      int     b;
      int     kind;
      int     drop_at;
      int     change_at;
      longint exp_err;
      longint exp_err8;
      string  name;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   fitness_evaluator dut (
      .clk(clk), .rst(rst), .start(start), .individual(individual),
      .finish(finish), .error(error), .busy(busy),
      .tableWe(tableWe), .tableAddr(tableAddr), .tableData(tableData)
   );

   fitness_evaluator #(.ErrorWidth(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .individual(individual),
      .finish(finish8), .error(error8), .busy(busy8),
      .tableWe(tableWe), .tableAddr(tableAddr), .tableData(tableData)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected score straight from the definition: sum of |a*x+b - t[x]|, capped.
   function automatic longint model(input longint a, input longint b, input int ew);
      longint sum, y, lim;
      sum = 0;
      for (int x = 0; x < N; x++) begin
         y = a * x + b;
         sum += (y > tgt[x]) ? (y - tgt[x]) : (tgt[x] - y);
      end
      lim = (longint'(1) << ew) - 1;
      return (sum > lim) ? lim : sum;
   endfunction

   task automatic load_table(input int kind);
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       tgt[i] = 0;
            1:       tgt[i] = i;
            2:       tgt[i] = 3 * i + 2;
            default: tgt[i] = longint'($urandom_range(0, (1 << TW) - 1));
         endcase
         tableWe   = 1'b1;
         tableAddr = 4'(i);
         tableData = 21'(tgt[i]);
         tick();
      end
      tableWe = 1'b0;
   endtask

   // c counts edges after the capture edge; finish is due after edge N+1.
   task automatic run_eval(input int a, input int b, input int drop_at, input int change_at,
                           output longint err, output longint err8, output int lat,
                           output int pulse_ok, output int busy_ok);
      logic [31:0] av, bv;
      av = 32'(a);
      bv = 32'(b);
      individual = {av[15:0], bv[15:0]};
      start = 1'b1;
      tick();
      lat = -1;
      busy_ok = 1;
      for (int c = 1; c <= 40; c++) begin
         if (c - 1 == drop_at) start = 1'b0;
         if (c - 1 == change_at) individual = {16'd7, 16'd9};
         tick();
         if (!busy || !busy8) busy_ok = 0;
         if (finish || finish8) begin
            lat = (finish && finish8) ? c : -2;
            break;
         end
      end
      err  = longint'(error);
      err8 = longint'(error8);
      start = 1'b0;
      tick();
      pulse_ok = (!finish && busy && longint'(error) == err) ? 1 : 0;
      tick();
   endtask

   initial begin
      longint err, err8;
      int lat, pulse_ok, busy_ok, cnt, gap;

      rst = 1'b1; start = 1'b0; tableWe = 1'b0;
      individual = '0; tableAddr = '0; tableData = '0;
      tick();
      tick();
      chk("reset_finish", longint'(finish), 0);
      chk("reset_error", longint'(error), 0);
      chk("reset_busy", longint'(busy), 0);
      rst = 1'b0;
      tick();

      vecs[0] = '{0, 5, 0, BIG, BIG, 80, 80, "zero_a0_b5_held"};
      vecs[1] = '{1, 0, 1, 0, 3, 0, 0, "ident_a1_b0_midchange"};
      vecs[2] = '{3, 0, 2, 2, BIG, 32, 32, "3x2_a3_b0_drop2"};
      vecs[3] = '{65535, 65535, 0, 0, BIG, 8912760, 255, "zero_max_saturate"};
      vecs[4] = '{0, 1, 0, 0, BIG, 16, 16, "zero_a0_b1"};

      for (int v = 0; v < 5; v++) begin
         load_table(vecs[v].kind);
         run_eval(vecs[v].a, vecs[v].b, vecs[v].drop_at, vecs[v].change_at,
                  err, err8, lat, pulse_ok, busy_ok);
         chk({vecs[v].name, "_error"}, err, vecs[v].exp_err);
         chk({vecs[v].name, "_error8"}, err8, vecs[v].exp_err8);
         chk({vecs[v].name, "_latency"}, lat, N + 1);
         chk({vecs[v].name, "_busy"}, busy_ok, 1);
         chk({vecs[v].name, "_pulse"}, pulse_ok, 1);
      end

      // Reset in the middle of RUN: no finish, outputs back to reset values.
      individual = {16'd0, 16'd5};
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_finish", longint'(finish), 0);
      chk("abort_error", longint'(error), 0);
      chk("abort_busy", longint'(busy), 0);
      cnt = 0;
      repeat (30) begin
         tick();
         if (finish) cnt++;
      end
      chk("abort_no_finish", cnt, 0);
      run_eval(0, 1, 0, BIG, err, err8, lat, pulse_ok, busy_ok);
      chk("after_abort_error", err, 16);

      // Table write during RUN must be dropped.
      individual = {16'd0, 16'd0};
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      tableWe = 1'b1; tableAddr = 4'd0; tableData = 21'd100;
      tick();
      tableWe = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("drop_write_idle", longint'(busy), 0);
      run_eval(0, 0, 0, BIG, err, err8, lat, pulse_ok, busy_ok);
      chk("drop_write_error", err, 0);

      // Level start held: evaluations back to back, finishes N+4 apart.
      individual = {16'd0, 16'd0};
      start = 1'b1;
      cnt = 0;
      while (!finish && cnt < 40) begin
         tick();
         cnt++;
      end
      gap = 0;
      do begin
         tick();
         gap++;
      end while (!finish && gap < 40);
      chk("back_to_back_gap", gap, N + 4);
      chk("back_to_back_error", longint'(error), 0);
      start = 1'b0;
      repeat (N + 6) tick();

      // Random tables and individuals against the model, both error widths.
      for (int r = 0; r < 6; r++) begin
         int a, b;
         load_table(3);
         a = (r % 2 == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 8));
         b = int'($urandom_range(0, 65535));
         run_eval(a, b, 0, BIG, err, err8, lat, pulse_ok, busy_ok);
         chk($sformatf("rand%0d_a%0d_b%0d_error", r, a, b), err, model(a, b, 32));
         chk($sformatf("rand%0d_error8", r), err8, model(a, b, 8));
         chk($sformatf("rand%0d_latency", r), lat, N + 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fitness_evaluator.md
Name: fitness_evaluator

Overview:
- Responder end of the GA fitness handshake. It accepts an individual on a level `start`, scores it against a target sample table, and returns an error with a one-cycle `finish` pulse.
- The individual encodes a line y = a*x + b. Error is the saturating sum of |y(x) - target[x]| over all 2^SampleAddressWidth sample points.
- It sits beside the GA core, which drives `start`/`individual` and writes `finish`/`error` into its fitness cache.

Parameters:
- IndividualWidth, 32, individual width; must be even. a = individual[IW-1:IW/2], b = individual[IW/2-1:0], both unsigned.
- ErrorWidth, 32, width of the accumulated error output.
- SampleAddressWidth, 4, log2 of sample count N. x runs 0..N-1.
- TargetWidth, IndividualWidth/2+SampleAddressWidth+1, width of each target sample.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request. The individual is held stable by the requester while start is high.
- individual  in  IndividualWidth  candidate to score.
- finish  out  1  one-cycle pulse; `error` is valid in this cycle.
- error  out  ErrorWidth  result; holds its value until the next finish.
- busy  out  1  high in any state other than IDLE.
- tableWe  in  1  target table write enable.
- tableAddr  in  SampleAddressWidth  target table write address.
- tableData  in  TargetWidth  target table write data.

Behaviour:
- Reset is synchronous only. On rst=1 at a clock edge:
  - state=IDLE; finish=0; error=0; busy=0;
  - accumulator and sample counter cleared.
  - Target table contents are not reset.
  - A reset during RUN aborts the evaluation; no finish is produced.
- States: IDLE, RUN, FINISH, HOLD.
- IDLE: if start=1 at an edge:
  - capture a and b into internal registers;
  - clear the accumulator;
  - set x=0 and go to RUN.
  - Changes on `individual` after capture have no effect.
- RUN: the table is read with 1-cycle latency.
  - Cycle i (0..N-1) issues read address x=i.
  - Cycle i+1 accumulates |a*i + b - target[i]|.
  - Product width is IW/2+SampleAddressWidth; the sum is one bit wider; the difference is taken as a magnitude.
  - The accumulator saturates at all-ones of ErrorWidth and never wraps.
  - After the N-th accumulate, go to FINISH.
- FINISH: finish=1 and error=accumulator for exactly one cycle, then go to HOLD.
- HOLD: one cycle with start ignored, covering the requester's cache-hit cycle; then go to IDLE.
- Latency: start captured at edge k means finish is high in the cycle following edge k+N+1, i.e. N+2 cycles.
- Throughput: one evaluation per N+4 cycles.
- If start is still high on return to IDLE, a new evaluation begins (level semantics).
- start=0 during RUN does not abort the evaluation.
- Table writes:
  - Accepted only when busy=0.
  - tableWe while busy=1 is dropped silently, so the table is stable during an evaluation.
  - A write in the same cycle as a start capture in IDLE is accepted, and is visible to that evaluation because the first read occurs the next cycle.
- A write to the address being read returns the old data (read-before-write). This case cannot arise during RUN.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, RUN, FINISH, HOLD);
  - helper function for saturating add;
  - helper function for absolute difference.
- Sub-module fitness_target_table: synchronous-read, single-write-port RAM of 2^SampleAddressWidth x TargetWidth with registered read data.

Test Plan:
- Table all 0; individual a=0, b=5; start held high until finish → finish exactly 18 cycles after capture, error=80, busy high throughout, single-cycle pulse.
- Table target[x]=x; a=1, b=0 → error=0. Then change `individual` mid-RUN to a=7, b=9 → error still 0.
- Table target[x]=3x+2; a=3, b=0 → error=32. Start dropped two cycles after capture → evaluation still completes with error=32.
- ErrorWidth=8 override, table all 0, a=0xFFFF, b=0xFFFF → error=255 (saturated, no wrap).
- rst pulsed at RUN cycle 5 → no finish, error=0, busy=0. A subsequent start with a=0, b=1 on a zero table → error=16.
- tableWe during RUN writing target[0]=100 is dropped: the next evaluation with a=0, b=0 on a zero table gives error=0. Start held continuously → back-to-back finishes N+4=20 cycles apart.
